// File: rtl/trng_pkg.sv
// Shared types and constants for the TRNG entropy pool.
package trng_pkg;

   localparam int TRNG_WORD_W = 32;

   typedef logic [TRNG_WORD_W-1:0] trng_word_t;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DRAIN
   } pool_state_t;

endpackage

// File: rtl/trng_word_fifo.sv
// First-word-fall-through circular FIFO holding health-passed entropy words.
module trng_word_fifo
   import trng_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int DATA_W = TRNG_WORD_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [DATA_W-1:0]        din,
   output logic [DATA_W-1:0]        dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = (AW)'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_FULL);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   // Head word is forced to zero when nothing is stored so the output never shows stale data.
   assign dout    = empty ? '0 : mem[rd_ptr];

   // Storage array: data only, no reset needed.
   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         if (do_push && !do_pop) begin
            count <= count + CNT_ONE;
         end else if (!do_push && do_pop) begin
            count <= count - CNT_ONE;
         end
      end
   end

endmodule

// File: rtl/trng_entropy_pool.sv
// TRNG handshake FSM, repetition-count health test and entropy FIFO glue.
module trng_entropy_pool
   import trng_pkg::*;
#(
   parameter int DEPTH     = 8,
   parameter int REP_LIMIT = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   output logic                     trng_request,
   input  logic [TRNG_WORD_W-1:0]   trng_random_number,
   input  logic                     trng_ready,
   output logic [TRNG_WORD_W-1:0]   rnd_data,
   output logic                     rnd_valid,
   input  logic                     rnd_ready,
   output logic [$clog2(DEPTH):0]   fill_level,
   output logic                     health_fail,
   input  logic                     health_clear
);

   localparam logic [3:0] LIMIT = 4'(REP_LIMIT);

   pool_state_t state;
   pool_state_t state_next;
   logic        capture;
   logic        is_repeat;
   logic        fail_now;
   logic [3:0]  rep_cnt;
   logic [3:0]  rep_next;
   logic        have_last;
   trng_word_t  last_word;
   logic        push;
   logic        pop;
   logic        fifo_empty;
   logic        fifo_full;

   // State register; DRAIN after reset so a word left on the bus is never captured.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= DRAIN;
      else        state <= state_next;
   end

   // Request handshake: one word in flight, DRAIN waits for trng_ready to drop.
   always_comb begin
      state_next   = state;
      trng_request = 1'b0;
      capture      = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_full && !health_fail) state_next = REQ;
         end
         REQ: begin
            trng_request = 1'b1;
            if (trng_ready) begin
               capture    = 1'b1;
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (!trng_ready) state_next = IDLE;
         end
         default: state_next = DRAIN;
      endcase
   end

   // Repetition count for the word on the bus; the first word after reset/clear always passes.
   always_comb begin
      is_repeat = have_last && (trng_random_number == last_word);
      rep_next  = 4'd1;
      if (is_repeat) begin
         rep_next = (rep_cnt >= LIMIT) ? rep_cnt : rep_cnt + 4'd1;
      end
      fail_now = capture && (rep_next >= LIMIT);
   end

   // Health state; a failing capture outranks a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         health_fail <= 1'b0;
         rep_cnt     <= '0;
         have_last   <= 1'b0;
         last_word   <= '0;
      end else if (fail_now) begin
         health_fail <= 1'b1;
         rep_cnt     <= rep_next;
      end else if (health_clear) begin
         health_fail <= 1'b0;
         rep_cnt     <= '0;
         have_last   <= 1'b0;
      end else if (capture) begin
         rep_cnt   <= rep_next;
         have_last <= 1'b1;
         if (!is_repeat) last_word <= trng_random_number;
      end
   end

   assign push      = capture && !fail_now;
   assign rnd_valid = !fifo_empty && !health_fail;
   assign pop       = rnd_valid && rnd_ready;

   trng_word_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (TRNG_WORD_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (fail_now),
      .din   (trng_random_number),
      .dout  (rnd_data),
      .count (fill_level),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

endmodule
